// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link between the boot checker (master) and the SysID control slave.
interface sysid_boot_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest
  );
endinterface

// File: rtl/sysid_boot_checker.sv
// Reads SysID word 0 (ID) and word 1 (timestamp), compares them against expected values and
// publishes pass/fail/timeout; 2*(READ_LATENCY+1)+1 cycles launch-to-done without stalls.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1617217248,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  sysid_boot_checker_if.master        avm,
  output logic [31:0]                 id_value,
  output logic [31:0]                 ts_value,
  output logic                        busy,
  output logic                        done,
  output logic                        id_ok,
  output logic                        ts_ok,
  output logic                        timeout
);

  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE} state_t;

  localparam bit        NO_LAT   = (READ_LATENCY == 0);
  localparam logic [1:0] LAT_LAST = 2'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic [1:0]  lat_cnt, lat_cnt_nxt;
  logic        auto_pend;
  logic        id_got, id_got_nxt, ts_got, ts_got_nxt;
  logic [31:0] id_nxt, ts_nxt;
  logic        launch, to_hit, capture;

  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = '0;
    lat_cnt_nxt     = '0;
    id_nxt          = id_value;
    ts_nxt          = ts_value;
    id_got_nxt      = id_got;
    ts_got_nxt      = ts_got;
    launch          = 1'b0;
    to_hit          = 1'b0;
    capture         = 1'b0;
    avm.avm_read    = 1'b0;
    avm.avm_address = 1'b0;

    case (state)
      IDLE: begin
        if (start || auto_pend) begin
          launch     = 1'b1;
          id_got_nxt = 1'b0;
          ts_got_nxt = 1'b0;
          state_nxt  = RD_ID;
        end
      end
      RD_ID, RD_TS: begin
        avm.avm_read    = 1'b1;
        avm.avm_address = (state == RD_TS);
        if (!avm.avm_waitrequest) begin
          if (NO_LAT) capture = 1'b1;
          else        state_nxt = (state == RD_ID) ? LAT_ID : LAT_TS;
        end else if (wait_cnt == TO_LAST) begin
          to_hit    = 1'b1;
          state_nxt = DONE;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end
      LAT_ID, LAT_TS: begin
        if (lat_cnt == LAT_LAST) capture = 1'b1;
        else                     lat_cnt_nxt = lat_cnt + 2'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Capture happens either in the accept cycle (zero latency) or on the last latency cycle.
    if (capture) begin
      if (state == RD_TS || state == LAT_TS) begin
        ts_nxt     = avm.avm_readdata;
        ts_got_nxt = 1'b1;
        state_nxt  = DONE;
      end else begin
        id_nxt     = avm.avm_readdata;
        id_got_nxt = 1'b1;
        state_nxt  = RD_TS;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      lat_cnt   <= '0;
      auto_pend <= AUTO_START;
      id_got    <= 1'b0;
      ts_got    <= 1'b0;
      id_value  <= '0;
      ts_value  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      id_ok     <= 1'b0;
      ts_ok     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      lat_cnt   <= lat_cnt_nxt;
      auto_pend <= 1'b0;
      id_got    <= id_got_nxt;
      ts_got    <= ts_got_nxt;
      id_value  <= id_nxt;
      ts_value  <= ts_nxt;
      if (launch) begin
        busy    <= 1'b1;
        done    <= 1'b0;
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
        timeout <= 1'b0;
      end
      // Results become visible in the DONE cycle itself, using the words as they land.
      if (state != DONE && state_nxt == DONE) begin
        busy    <= 1'b0;
        done    <= 1'b1;
        timeout <= to_hit;
        id_ok   <= id_got_nxt && (id_nxt == EXPECTED_ID);
        ts_ok   <= ts_got_nxt && (ts_nxt == EXPECTED_TS);
      end
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Two checkers (zero-latency/short timeout with auto start, latency-2 without auto start)
// against a SysID slave model with randomized stalls and data.
module tb_sysid_boot_checker;
  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1617217248;
  localparam int          STUCK  = 65535;

  int n_checks = 0;
  int n_fail   = 0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_a   [2] = '{1'b0, 1'b0};
  logic        start_a [2] = '{1'b0, 1'b0};
  logic        busy_a  [2];
  logic        done_a  [2];
  logic        idok_a  [2];
  logic        tsok_a  [2];
  logic        to_a    [2];
  logic [31:0] idv_a   [2];
  logic [31:0] tsv_a   [2];
  logic        rd_a    [2];
  logic        addr_a  [2];
  logic        wreq_a  [2] = '{1'b0, 1'b0};
  logic [31:0] rdata_a [2] = '{32'h0, 32'h0};

  int          cfg_stall [2][2];
  logic [31:0] cfg_word  [2][2];
  int          stall_done [2] = '{0, 0};
  int          lat_left   [2] = '{0, 0};
  logic        lat_addr   [2] = '{1'b0, 1'b0};
  logic        req_addr   [2] = '{1'b0, 1'b0};
  int          viol_out   [2] = '{0, 0};
  int          viol_stab  [2] = '{0, 0};

  sysid_boot_checker_if bus0 ();
  sysid_boot_checker_if bus1 ();

  assign rd_a[0]   = bus0.avm_read;
  assign addr_a[0] = bus0.avm_address;
  assign rd_a[1]   = bus1.avm_read;
  assign addr_a[1] = bus1.avm_address;
  assign bus0.avm_waitrequest = wreq_a[0];
  assign bus0.avm_readdata    = rdata_a[0];
  assign bus1.avm_waitrequest = wreq_a[1];
  assign bus1.avm_readdata    = rdata_a[1];

  sysid_boot_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(0),
    .TIMEOUT_CYCLES(8), .AUTO_START(1'b1)
  ) u_dut0 (
    .clock(clock), .reset_n(rst_a[0]), .start(start_a[0]), .avm(bus0),
    .id_value(idv_a[0]), .ts_value(tsv_a[0]), .busy(busy_a[0]), .done(done_a[0]),
    .id_ok(idok_a[0]), .ts_ok(tsok_a[0]), .timeout(to_a[0])
  );

  sysid_boot_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(2),
    .TIMEOUT_CYCLES(255), .AUTO_START(1'b0)
  ) u_dut1 (
    .clock(clock), .reset_n(rst_a[1]), .start(start_a[1]), .avm(bus1),
    .id_value(idv_a[1]), .ts_value(tsv_a[1]), .busy(busy_a[1]), .done(done_a[1]),
    .id_ok(idok_a[1]), .ts_ok(tsok_a[1]), .timeout(to_a[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic int tmo_of(input int k);
    return (k == 0) ? 8 : 255;
  endfunction

  // Slave model: stalls each request for its configured count, then returns the word
  // after the fixed latency; readdata carries random garbage in every other cycle.
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      rdata_a[k] = $urandom;
      if (rd_a[k] && lat_left[k] > 0) viol_out[k]++;
      if (lat_left[k] > 0) begin
        lat_left[k]--;
        if (lat_left[k] == 0) rdata_a[k] = cfg_word[k][lat_addr[k]];
      end
      if (rd_a[k]) begin
        if (stall_done[k] > 0 && addr_a[k] != req_addr[k]) viol_stab[k]++;
        req_addr[k] = addr_a[k];
        if (stall_done[k] < cfg_stall[k][addr_a[k]]) begin
          wreq_a[k] = 1'b1;
          stall_done[k]++;
        end else begin
          wreq_a[k]     = 1'b0;
          stall_done[k] = 0;
          if (lat_of(k) == 0) rdata_a[k] = cfg_word[k][addr_a[k]];
          else begin
            lat_left[k] = lat_of(k);
            lat_addr[k] = addr_a[k];
          end
        end
      end else begin
        wreq_a[k]     = 1'($urandom_range(0, 1));
        stall_done[k] = 0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] status_of(input int k);
    return {busy_a[k], done_a[k], idok_a[k], tsok_a[k], to_a[k], rd_a[k], addr_a[k]};
  endfunction

  task automatic set_cfg(input int k, input int s0, input int s1,
                         input logic [31:0] w0, input logic [31:0] w1);
    cfg_stall[k][0] = s0;
    cfg_stall[k][1] = s1;
    cfg_word[k][0]  = w0;
    cfg_word[k][1]  = w1;
  endtask

  function automatic int pick_stall(input int t);
    int r;
    r = $urandom_range(0, 9);
    if (r < 4)  return 0;
    if (r < 7)  return $urandom_range(1, 6);
    if (r == 7) return t - 1;
    if (r == 8) return t;
    return STUCK;
  endfunction

  task automatic rand_cfg(input int k);
    logic [31:0] w0, w1;
    w0 = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
    w1 = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
    set_cfg(k, pick_stall(tmo_of(k)), pick_stall(tmo_of(k)), w0, w1);
  endtask

  // Caller sits just after a negedge; the current cycle is cycle 0 of the check.
  task automatic run_check(input int k, input bit use_start, input bit dbl_busy, input bit dbl_done);
    int s0, s1, t, rl, exp_d, exp_rd, n, rdc, vo, vs, idle_hits;
    bit to_id, to_ts, seen;
    logic [31:0] w0, w1;
    s0 = cfg_stall[k][0];
    s1 = cfg_stall[k][1];
    w0 = cfg_word[k][0];
    w1 = cfg_word[k][1];
    t  = tmo_of(k);
    rl = lat_of(k);
    to_id  = (s0 >= t);
    to_ts  = !to_id && (s1 >= t);
    exp_d  = to_id ? t + 1 : to_ts ? 1 + (s0 + 1 + rl) + t : 1 + (s0 + 1 + rl) + (s1 + 1 + rl);
    exp_rd = to_id ? t : to_ts ? s0 + 1 + t : s0 + s1 + 2;
    vo = viol_out[k];
    vs = viol_stab[k];
    n = 0;
    rdc = 0;
    seen = 1'b0;
    if (use_start) start_a[k] = 1'b1;
    while (!seen && n < 1000) begin
      @(posedge clock);
      @(negedge clock);
      n++;
      start_a[k] = dbl_busy && (n == 2);
      if (rd_a[k]) rdc++;
      if (n == 1) check_eq("busy_at_launch", 32'(busy_a[k]), 32'd1);
      seen = done_a[k];
    end
    check_eq("done_cycle", n, exp_d);
    check_eq("busy_at_done", 32'(busy_a[k]), 32'd0);
    check_eq("timeout", 32'(to_a[k]), 32'(to_id || to_ts));
    check_eq("id_ok", 32'(idok_a[k]), 32'(!to_id && (w0 == EXP_ID)));
    check_eq("ts_ok", 32'(tsok_a[k]), 32'(!to_id && !to_ts && (w1 == EXP_TS)));
    if (!to_id) check_eq("id_value", idv_a[k], w0);
    if (!to_id && !to_ts) check_eq("ts_value", tsv_a[k], w1);
    check_eq("read_cycles", rdc, exp_rd);
    check_eq("one_outstanding", viol_out[k] - vo, 32'd0);
    check_eq("req_stable", viol_stab[k] - vs, 32'd0);
    start_a[k] = dbl_done;
    idle_hits = 0;
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      start_a[k] = 1'b0;
      if (busy_a[k] || rd_a[k]) idle_hits++;
    end
    check_eq("idle_after_done", idle_hits, 32'd0);
  endtask

  initial begin
    int hits;
    for (int k = 0; k < 2; k++) set_cfg(k, 0, 0, EXP_ID, EXP_TS);
    repeat (3) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      check_eq("reset_status", 32'(status_of(k)), 32'd0);
      check_eq("reset_id_value", idv_a[k], 32'd0);
      check_eq("reset_ts_value", tsv_a[k], 32'd0);
    end

    // Auto start on reset release for instance 0; instance 1 must stay idle.
    rst_a[0] = 1'b1;
    rst_a[1] = 1'b1;
    run_check(0, 1'b0, 1'b0, 1'b0);
    hits = 0;
    repeat (4) begin
      @(posedge clock);
      @(negedge clock);
      if (busy_a[1] || rd_a[1]) hits++;
    end
    check_eq("no_auto_start", hits, 32'd0);

    set_cfg(0, 0, 0, 32'h0000_0001, EXP_TS);
    run_check(0, 1'b1, 1'b0, 1'b0);
    set_cfg(0, 4, 4, EXP_ID, EXP_TS);
    run_check(0, 1'b1, 1'b1, 1'b0);
    set_cfg(0, STUCK, 0, EXP_ID, EXP_TS);
    run_check(0, 1'b1, 1'b0, 1'b1);
    set_cfg(0, 7, 8, EXP_ID, EXP_TS);
    run_check(0, 1'b1, 1'b0, 1'b0);
    set_cfg(0, 0, STUCK, EXP_ID, EXP_TS);
    run_check(0, 1'b1, 1'b1, 1'b1);
    repeat (10) begin
      rand_cfg(0);
      run_check(0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    set_cfg(1, 0, 0, EXP_ID, EXP_TS);
    run_check(1, 1'b1, 1'b0, 1'b0);
    set_cfg(1, 3, 1, EXP_ID, 32'h1234_5678);
    run_check(1, 1'b1, 1'b1, 1'b0);
    repeat (6) begin
      rand_cfg(1);
      run_check(1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the first LAT_TS cycle (cycle 5 at latency 2), then restart by hand.
    set_cfg(1, 0, 0, EXP_ID, EXP_TS);
    start_a[1] = 1'b1;
    repeat (5) begin
      @(posedge clock);
      @(negedge clock);
      start_a[1] = 1'b0;
    end
    check_eq("lat_ts_busy", 32'(busy_a[1]), 32'd1);
    check_eq("lat_ts_no_read", 32'(rd_a[1]), 32'd0);
    rst_a[1] = 1'b0;
    #1;
    check_eq("midrun_reset_status", 32'(status_of(1)), 32'd0);
    check_eq("midrun_reset_id_value", idv_a[1], 32'd0);
    check_eq("midrun_reset_ts_value", tsv_a[1], 32'd0);
    @(negedge clock);
    rst_a[1] = 1'b1;
    hits = 0;
    repeat (6) begin
      @(posedge clock);
      @(negedge clock);
      if (busy_a[1] || rd_a[1] || done_a[1]) hits++;
    end
    check_eq("post_reset_idle", hits, 32'd0);
    run_check(1, 1'b1, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
